// File: rtl/demux_stream_if.sv
// Stream bundle for demux_stream: one select-tagged input port and two
// buffered output channels, each with valid/ready handshakes.
interface demux_stream_if #(
    parameter int W = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_sel;

    logic         out0_valid;
    logic         out0_ready;
    logic [W-1:0] out0_data;

    logic         out1_valid;
    logic         out1_ready;
    logic [W-1:0] out1_data;

    // master: the source of input words and the consumer of both channels
    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data
    );
endinterface

// File: rtl/demux_stream.sv
// Two-way stream demultiplexer: routes each input word by its select bit into
// one of two independent FIFOs, with saturating accept counters and levels.
module demux_stream #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    demux_stream_if.slave          bus,
    output logic [7:0]             cnt0,
    output logic [7:0]             cnt1,
    output logic [$clog2(DEPTH):0] level0,
    output logic [$clog2(DEPTH):0] level1
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem  [2][DEPTH];
    logic [PW-1:0] wptr [2];
    logic [PW-1:0] rptr [2];
    logic [7:0]    cnt  [2];
    logic [PW-1:0] level [2];
    logic [W-1:0]  head [2];

    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] valid;
    logic [1:0] push;
    logic [1:0] pop;
    logic       in_ready;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    always_comb begin
        full  = '0;
        empty = '0;
        valid = '0;
        for (int k = 0; k < 2; k++) begin
            level[k] = '0;
            head[k]  = '0;
        end
        for (int k = 0; k < 2; k++) begin
            empty[k] = (wptr[k] == rptr[k]);
            full[k]  = (wptr[k][AW] != rptr[k][AW]) &&
                       (wptr[k][AW-1:0] == rptr[k][AW-1:0]);
            valid[k] = rst && !empty[k];
            level[k] = rst ? (wptr[k] - rptr[k]) : '0;
            head[k]  = valid[k] ? mem[k][rptr[k][AW-1:0]] : '0;
        end
    end

    always_comb begin
        in_ready = rst && !full[bus.in_sel];
        push     = '0;
        push[0]  = bus.in_valid && in_ready && !bus.in_sel;
        push[1]  = bus.in_valid && in_ready &&  bus.in_sel;
        pop      = '0;
        pop[0]   = valid[0] && bus.out0_ready;
        pop[1]   = valid[1] && bus.out1_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                wptr[k] <= '0;
                rptr[k] <= '0;
                cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    wptr[k] <= wptr[k] + PW'(1);
                    if (cnt[k] != 8'hFF)
                        cnt[k] <= cnt[k] + 8'd1;
                end
                if (pop[k])
                    rptr[k] <= rptr[k] + PW'(1);
            end
        end
    end

    // Storage is deliberately left out of reset; only pointers define contents.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k])
                mem[k][wptr[k][AW-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out0_valid = valid[0];
    assign bus.out1_valid = valid[1];
    assign bus.out0_data  = head[0];
    assign bus.out1_data  = head[1];

    assign cnt0   = rst ? cnt[0] : 8'd0;
    assign cnt1   = rst ? cnt[1] : 8'd0;
    assign level0 = level[0];
    assign level1 = level[1];
endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: per-channel queues hold expected words
// on accept and are compared against the DUT heads every cycle.
module tb_demux_stream;
    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [2:0] level0;
    logic [2:0] level1;

    demux_stream_if #(.W(W)) bus ();

    demux_stream #(.W(W), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .cnt0   (cnt0),
        .cnt1   (cnt1),
        .level0 (level0),
        .level1 (level1)
    );

    always #5 clk = ~clk;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int m_cnt0 = 0;
    int m_cnt1 = 0;
    int n_checks = 0;
    int n_pass = 0;
    int max_level0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_in(input bit v, input bit s, input logic [W-1:0] d,
                          input bit r0, input bit r1);
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
    endtask

    // Compare outputs against the queue model, then advance one clock.
    task automatic step();
        logic         acc;
        logic         sel;
        logic         p0;
        logic         p1;
        logic [W-1:0] d;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        logic [W-1:0] junk;
        #1;
        e0 = '0;
        e1 = '0;
        if (rst && q0.size() != 0) e0 = q0[0];
        if (rst && q1.size() != 0) e1 = q1[0];
        chk("in_ready", bus.in_ready,
            rst && (bus.in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH)));
        chk("out0_valid", bus.out0_valid, rst && q0.size() != 0);
        chk("out1_valid", bus.out1_valid, rst && q1.size() != 0);
        chk("out0_data", bus.out0_data, e0);
        chk("out1_data", bus.out1_data, e1);
        chk("level0", level0, rst ? q0.size() : 0);
        chk("level1", level1, rst ? q1.size() : 0);
        chk("cnt0", cnt0, rst ? m_cnt0 : 0);
        chk("cnt1", cnt1, rst ? m_cnt1 : 0);
        if (int'(level0) > max_level0) max_level0 = int'(level0);
        acc = bus.in_valid && bus.in_ready;
        sel = bus.in_sel;
        d   = bus.in_data;
        p0  = bus.out0_valid && bus.out0_ready;
        p1  = bus.out1_valid && bus.out1_ready;
        @(posedge clk);
        if (!rst) begin
            q0.delete();
            q1.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            if (p0 && q0.size() != 0) junk = q0.pop_front();
            if (p1 && q1.size() != 0) junk = q1.pop_front();
            if (acc) begin
                if (sel) begin
                    q1.push_back(d);
                    if (m_cnt1 < 255) m_cnt1++;
                end else begin
                    q0.push_back(d);
                    if (m_cnt0 < 255) m_cnt0++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input bit s, input logic [W-1:0] d,
                         input bit r0, input bit r1);
        set_in(v, s, d, r0, r1);
        step();
    endtask

    initial begin
        int accepted;
        int guard;

        // reset held with a word offered
        rst = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 4'hA, 1'b1, 1'b1);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out0_data", bus.out0_data, 0);
        chk("rst_level0", level0, 0);
        rst = 1'b1;
        set_in(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out0_valid", bus.out0_valid, 0);

        // routing and order
        drive(1'b1, 1'b0, 4'hA, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 4'h5, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 4'h3, 1'b1, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("route_cnt0", cnt0, 2);
        chk("route_cnt1", cnt1, 1);

        // fill channel 0, side traffic on channel 1, single pop
        for (int i = 1; i <= 4; i++) drive(1'b1, 1'b0, 4'(i), 1'b0, 1'b1);
        chk("fill_level0", level0, 4);
        set_in(1'b1, 1'b0, 4'h5, 1'b0, 1'b1);
        #1 chk("full_in_ready", bus.in_ready, 0);
        step();
        set_in(1'b1, 1'b1, 4'h9, 1'b0, 1'b1);
        #1 chk("sel1_in_ready", bus.in_ready, 1);
        step();
        chk("out1_nine", bus.out1_data, 9);
        set_in(1'b1, 1'b0, 4'h5, 1'b1, 1'b1);
        #1 chk("full_pop_in_ready", bus.in_ready, 0);
        step();
        set_in(1'b1, 1'b0, 4'h5, 1'b0, 1'b1);
        #1 chk("after_pop_in_ready", bus.in_ready, 1);
        step();
        chk("refill_level0", level0, 4);
        chk("refill_head", bus.out0_data, 2);
        repeat (6) drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("drain_level0", level0, 0);

        // wrap-around: push every cycle, pop every other cycle
        max_level0 = 0;
        accepted = 0;
        guard = 0;
        while (accepted < 10 && guard < 60) begin
            set_in(1'b1, 1'b0, 4'(accepted + 6), guard[0], 1'b1);
            #1;
            if (bus.in_ready) accepted++;
            step();
            guard++;
        end
        chk("wrap_accepted", accepted, 10);
        repeat (6) drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("wrap_max_level_ok", max_level0 <= 4, 1);
        chk("wrap_cnt0", cnt0, 17);

        // simultaneous push and pop at level 2
        drive(1'b1, 1'b0, 4'hB, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 4'hC, 1'b0, 1'b1);
        chk("simul_level_before", level0, 2);
        drive(1'b1, 1'b0, 4'hD, 1'b1, 1'b1);
        chk("simul_level_after", level0, 2);
        chk("simul_head", bus.out0_data, 4'hC);
        repeat (4) drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

        // counter saturation on channel 1
        for (int i = 0; i < 260; i++) drive(1'b1, 1'b1, 4'(i), 1'b1, 1'b1);
        chk("sat_cnt1", cnt1, 255);

        // mid-operation reset with words buffered
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'(i + 1), 1'b0, 1'b1);
        chk("pre_rst_level0", level0, 3);
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'hE, 1'b1, 1'b1);
        rst = 1'b1;
        set_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        chk("mid_rst_level0", level0, 0);
        chk("mid_rst_out0_valid", bus.out0_valid, 0);
        chk("mid_rst_cnt0", cnt0, 0);
        chk("mid_rst_cnt1", cnt1, 0);
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/demux_stream.md
# demux_stream

Two-way stream demultiplexer. It accepts 4-bit words with a select bit on a valid/ready input port and routes each word to one of two buffered output channels. It is the receive-side counterpart of the 2:1 `mux` datapath: words that were merged onto one stream are split back into channel 0 and channel 1. Each channel has its own FIFO, so a stalled consumer on one channel does not block traffic bound for the other once the input word is for a non-full channel.

## Interface
- `W`, 4: data width of input and output words.
- `DEPTH`, 4: entries per channel FIFO; must be a power of 2 and at least 2.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  input word present.
- `in_ready`  output  1  block can accept the word for the current `in_sel`.
- `in_data`  input  W  input word.
- `in_sel`  input  1  destination: 0 routes to channel 0, 1 routes to channel 1.
- `out0_valid`, `out1_valid`  output  1  channel FIFO non-empty.
- `out0_ready`, `out1_ready`  input  1  consumer takes the head word.
- `out0_data`, `out1_data`  output  W  channel head word.
- `cnt0`, `cnt1`  output  8  words accepted per channel; saturating.
- `level0`, `level1`  output  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Each channel FIFO is a DEPTH×W memory with write and read pointers of $clog2(DEPTH)+1 bits. Pointers wrap modulo 2·DEPTH.
  - full: the MSBs differ and the lower bits are equal.
  - empty: the pointers are equal.
- `in_ready` = rst && !full[in_sel]. It is combinational from `in_sel` and FIFO state.
  - The source must hold `in_data` and `in_sel` stable while `in_valid`=1 and `in_ready`=0.
- Push: when `in_valid`&&`in_ready`, write `in_data` at wptr[in_sel], increment that wptr, and increment cnt[in_sel].
  - The counters saturate at 255 and do not wrap.
- `outK_valid` = !emptyK. `outK_data` = mem_K[rptr_K] when non-empty, otherwise all zeros.
- Pop: when `outK_valid`&&`outK_ready`, increment rptr_K.
  - Asserting `outK_ready` while empty has no effect.
- Push and pop on the same channel in the same cycle, FIFO non-empty and not full: both occur, and the level is unchanged.
- Full FIFO with a pop in the same cycle: `in_ready` stays 0 for that channel. There is no pass-through on full, and the push takes place in the following cycle.
- Empty FIFO with a push: there is no bypass. The word is not visible at the output until the next cycle.
- Pushes to channel X and pops from channel Y are fully independent in the same cycle.
- `levelK` = wptr_K − rptr_K, using modulo arithmetic on the pointer width.
- Ordering: words leave each channel in acceptance order. There is no ordering guarantee between the two channels.

## Timing
- Reset (rst=0 sampled at a rising edge) clears all pointers, `cnt0`/`cnt1`, and `level0`/`level1` to 0. Memory contents are not reset.
- While rst=0: `in_ready`=0, `out0_valid`=`out1_valid`=0, `out0_data`=`out1_data`=0, counts and levels are 0.
- In the first cycle after reset deassertion: `in_ready`=1 and both output valids are 0.
- Reset mid-operation discards all buffered words at that edge. A handshake presented in the same cycle as reset is not accepted.
- Latency: a word accepted at edge N drives `outK_valid`=1 and `outK_data` from edge N onward, so it is first poppable at edge N+1. Minimum input-to-output latency is 1 cycle.
- Throughput: 1 word per cycle sustained per channel when the consumer holds ready=1.
- `cnt`/`level` update at the same edge as the push or pop that changes them.

## Test plan
- **Reset values:** hold rst=0 for 3 cycles with in_valid=1 → in_ready=0, both valids=0, both data=0, counts and levels=0. Release reset → in_ready=1 on the next cycle.
- **Routing and order:** push A, 5, 3 with sel 0,1,0 while both readys=1 → out0 emits A then 3, out1 emits 5. Each word appears 1 cycle after its accept. cnt0=2, cnt1=1.
- **Fill and full:** with out0_ready=0, push 4 words (1,2,3,4) with sel=0 → level0=4 and in_ready=0 for sel=0.
  - Switch in_sel=1 → in_ready=1 and push 9 → out1_data=9.
  - Pulse out0_ready for 1 cycle → out0 pops 1. The pending sel=0 word is accepted the cycle after, not in the same cycle.
- **Wrap-around:** stream 10 words with sel=0 while alternately pushing and popping → pointers wrap, order is preserved, level0 never exceeds 4, no words are lost.
- **Simultaneous push and pop:** with level0=2, push and pop channel 0 in the same cycle → level0 stays 2, and the head advances to the next word.
- **Saturation and mid-operation reset:** push 260 words to channel 1 with out1_ready=1 → cnt1=255. Then with level0=3, assert rst for 1 cycle → level0=0, out0_valid=0, cnt0=cnt1=0.
